// File: rtl/pulse_width_decoder_pkg.sv
// Shared types for the pulse width decoder.
// Holds the decoder FSM state encoding.
// Imported by the decoder top; no logic of its own.
package pulse_width_decoder_pkg;

    // ARMING is the reset state: a line already high when reset releases
    // must first be seen low before any pulse is measured.
    typedef enum logic [1:0] {
        ARMING  = 2'd0,
        IDLE    = 2'd1,
        MEASURE = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_width_decoder_saturating_counter.sv
// Saturating up-counter: counts enabled cycles, sticks at MAX_VALUE.
// Latency: count/saturated update on the edge after clear/enable.
// Backpressure: none; clear has priority over enable.
//
// Ports: clock, resetn (async active-low), clear (return to 0),
//        enable (advance one step), count (current value),
//        saturated (an enable arrived while count was already MAX_VALUE).
module saturating_counter #(
    parameter  int MAX_VALUE = 255,
    localparam int WIDTH     = $clog2(MAX_VALUE + 1)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             saturated
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clear) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (enable) begin
            if (count_q == WIDTH'(MAX_VALUE)) begin
                sat_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count     = count_q;
    assign saturated = sat_q;

endmodule

// File: rtl/pulse_width_decoder.sv
// Pulse width decoder: rejects short glitches, measures accepted pulses.
// Latency: strobes and result appear 1 cycle after the first low sample.
// Backpressure: single-entry valid/ready result; a new result while full is dropped.
//
// Ports: clock, resetn (async active-low), pulse_in (level to decode),
//        pulse_out / glitch (accept / reject strobes), width and
//        width_saturated (held result), width_valid / width_ready (handshake),
//        dropped (accepted result discarded because the register was full).
module pulse_width_decoder
    import pulse_width_decoder_pkg::*;
#(
    parameter  int MIN_LENGTH  = 2,
    parameter  int MAX_LENGTH  = 255,
    localparam int COUNT_WIDTH = $clog2(MAX_LENGTH + 1)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   pulse_in,
    output logic                   pulse_out,
    output logic                   glitch,
    output logic [COUNT_WIDTH-1:0] width,
    output logic                   width_saturated,
    output logic                   width_valid,
    input  logic                   width_ready,
    output logic                   dropped
);

    state_t                 state_q, state_d;
    logic                   cnt_clear, cnt_en;
    logic [COUNT_WIDTH-1:0] cnt_count;
    logic                   cnt_sat;
    logic                   pulse_end;
    logic                   accept, reject;
    logic                   load_ok;

    logic                   pulse_out_q, glitch_q, dropped_q;
    logic                   width_valid_q, width_sat_q;
    logic [COUNT_WIDTH-1:0] width_q;

    // The counter sits at 0 whenever no pulse is in flight, so the first
    // high sample in IDLE simply enables it to reach 1.
    saturating_counter #(
        .MAX_VALUE (MAX_LENGTH)
    ) u_counter (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (cnt_clear),
        .enable    (cnt_en),
        .count     (cnt_count),
        .saturated (cnt_sat)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ARMING;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        pulse_end = 1'b0;
        case (state_q)
            ARMING: begin
                cnt_clear = 1'b1;
                if (!pulse_in) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (pulse_in) begin
                    cnt_en  = 1'b1;
                    state_d = MEASURE;
                end else begin
                    cnt_clear = 1'b1;
                end
            end
            MEASURE: begin
                if (pulse_in) begin
                    cnt_en = 1'b1;
                end else begin
                    // This low sample ends the pulse and also re-arms, so a
                    // high on the very next sample starts a fresh measurement.
                    pulse_end = 1'b1;
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = ARMING;
            end
        endcase
    end

    assign accept  = pulse_end && (cnt_count >= COUNT_WIDTH'(MIN_LENGTH));
    assign reject  = pulse_end && !accept;
    // A consumer taking the held result this edge frees the slot for the new one.
    assign load_ok = !width_valid_q || width_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pulse_out_q   <= 1'b0;
            glitch_q      <= 1'b0;
            dropped_q     <= 1'b0;
            width_valid_q <= 1'b0;
            width_sat_q   <= 1'b0;
            width_q       <= '0;
        end else begin
            pulse_out_q <= accept;
            glitch_q    <= reject;
            dropped_q   <= accept && !load_ok;
            if (accept && load_ok) begin
                width_q       <= cnt_count;
                width_sat_q   <= cnt_sat;
                width_valid_q <= 1'b1;
            end else if (width_valid_q && width_ready) begin
                width_valid_q <= 1'b0;
            end
        end
    end

    assign pulse_out       = pulse_out_q;
    assign glitch          = glitch_q;
    assign dropped         = dropped_q;
    assign width_valid     = width_valid_q;
    assign width_saturated = width_sat_q;
    assign width           = width_q;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Self-checking bench for pulse_width_decoder (MIN_LENGTH 2, MAX_LENGTH 8).
// Directed scenarios followed by random pulse trains and random consumer stalls.
// Expected outputs come from a run-length model of the pulse stream.
module tb_pulse_width_decoder;

    localparam int MIN_L = 2;
    localparam int MAX_L = 8;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pulse_in = 1'b0;
    logic       width_ready = 1'b0;
    logic       pulse_out, glitch, width_saturated, width_valid, dropped;
    logic [3:0] width;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: armed once a low has been seen after reset,
    // run = number of consecutive high samples of the current pulse.
    bit m_armed;
    int m_run;
    bit m_vld;
    int m_w;
    bit m_sat;
    bit e_pout, e_gl, e_drop;

    pulse_width_decoder #(
        .MIN_LENGTH (MIN_L),
        .MAX_LENGTH (MAX_L)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .pulse_in        (pulse_in),
        .pulse_out       (pulse_out),
        .glitch          (glitch),
        .width           (width),
        .width_saturated (width_saturated),
        .width_valid     (width_valid),
        .width_ready     (width_ready),
        .dropped         (dropped)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_armed = 0;
        m_run   = 0;
        m_vld   = 0;
        m_w     = 0;
        m_sat   = 0;
        e_pout  = 0;
        e_gl    = 0;
        e_drop  = 0;
    endtask

    // Apply one sampled (pulse, ready) pair to the model.
    task automatic model_edge(input bit p, input bit r);
        int  len;
        bit  offer;
        e_pout = 0;
        e_gl   = 0;
        e_drop = 0;
        offer  = 0;
        len    = 0;
        if (!m_armed) begin
            if (!p) m_armed = 1;
        end else if (p) begin
            m_run++;
        end else if (m_run > 0) begin
            len   = m_run;
            m_run = 0;
            if (len >= MIN_L) begin
                e_pout = 1;
                offer  = 1;
            end else begin
                e_gl = 1;
            end
        end
        if (offer) begin
            if (!m_vld || r) begin
                m_w   = (len > MAX_L) ? MAX_L : len;
                m_sat = (len > MAX_L);
                m_vld = 1;
            end else begin
                e_drop = 1;
            end
        end else if (m_vld && r) begin
            m_vld = 0;
        end
    endtask

    task automatic chk_all();
        chk("pulse_out", pulse_out, e_pout);
        chk("glitch", glitch, e_gl);
        chk("dropped", dropped, e_drop);
        chk("width_valid", width_valid, m_vld);
        if (m_vld) begin
            chk("width", width, m_w);
            chk("width_saturated", width_saturated, m_sat);
        end
    endtask

    // Called 1 time unit after a rising edge; leaves the same way.
    task automatic step(input bit p, input bit r);
        pulse_in    = p;
        width_ready = r;
        @(posedge clock);
        model_edge(p, r);
        #1;
        chk_all();
    endtask

    task automatic pulse(input int len, input bit r);
        for (int i = 0; i < len; i++) step(1'b1, r);
        step(1'b0, r);
    endtask

    // Asserts reset away from the clock edge and checks the outputs
    // drop immediately, before any edge arrives.
    task automatic apply_reset(input bit p);
        pulse_in    = p;
        width_ready = 1'b0;
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("rst_pulse_out", pulse_out, 0);
        chk("rst_glitch", glitch, 0);
        chk("rst_dropped", dropped, 0);
        chk("rst_width_valid", width_valid, 0);
        chk("rst_width_saturated", width_saturated, 0);
        chk("rst_width", width, 0);
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        apply_reset(1'b0);

        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Single-cycle glitch
        pulse(1, 1'b1);
        chk("glitch_1cyc", glitch, 1);
        chk("glitch_no_valid", width_valid, 0);
        step(1'b0, 1'b1);

        // 3-cycle pulse consumed immediately
        pulse(3, 1'b1);
        chk("w3_pulse_out", pulse_out, 1);
        chk("w3_width", width, 3);
        step(1'b0, 1'b1);
        chk("w3_one_cycle", width_valid, 0);

        // Exactly MAX, then beyond MAX
        pulse(8, 1'b1);
        chk("w8_width", width, 8);
        chk("w8_sat", width_saturated, 0);
        pulse(11, 1'b1);
        chk("w11_width", width, 8);
        chk("w11_sat", width_saturated, 1);
        step(1'b0, 1'b1);

        // Back-to-back 2-cycle pulses while stalled
        pulse(2, 1'b0);
        pulse(2, 1'b0);
        chk("b2b_dropped", dropped, 1);
        chk("b2b_width_held", width, 2);
        repeat (3) step(1'b0, 1'b0);
        chk("b2b_still_valid", width_valid, 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        // Held result consumed on the same edge a new 4-cycle pulse ends
        pulse(3, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("swap_width", width, 4);
        chk("swap_no_drop", dropped, 0);
        step(1'b0, 1'b1);

        // Line high across reset release is ignored
        apply_reset(1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("arm_no_pulse_out", pulse_out, 0);
        chk("arm_no_glitch", glitch, 0);
        pulse(3, 1'b1);
        chk("arm_w3", width, 3);

        // Reset mid-pulse with a held result
        pulse(5, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        apply_reset(1'b1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);

        // Random pulse trains with random consumer stalls
        for (int b = 0; b < 500; b++) begin
            int len;
            bit lvl;
            len = $urandom_range(1, 11);
            lvl = b[0];
            for (int i = 0; i < len; i++) begin
                step(lvl, ($urandom_range(0, 3) != 0));
            end
            if ((b % 97) == 50) apply_reset(lvl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
